// File: rtl/fwd_pkg.sv
// fwd_pkg: shared tracker entry type, "no forward" select code and clog2 helper.
package fwd_pkg;
  localparam int SEL_NONE = 0;
  localparam int ENT_RD_W = 32;
  typedef struct packed {
    logic                valid;
    logic [ENT_RD_W-1:0] rd;
    logic                is_load;
  } fwd_ent_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: youngest-producer priority match of one source operand against the tracked stages.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int SEL_W      = 2
) (
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  used_i,
  input  fwd_ent_t              ents_i [FWD_DEPTH],
  output logic [SEL_W-1:0]      sel_o,
  output logic                  stall_o
);
  logic [SEL_W-1:0] hit;
  logic             ld;
  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit = SEL_W'(SEL_NONE);
    ld  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--)
      if (used_i && addr_i != '0 && ents_i[k-1].valid && ents_i[k-1].rd == ENT_RD_W'(addr_i)) begin
        hit = SEL_W'(k);
        ld  = (k == 1) && ents_i[k-1].is_load;
      end
    sel_o   = ld ? SEL_W'(SEL_NONE) : hit;
    stall_o = ld;
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks post-EX producers, resolves operand forwarding and load-use stalls.
// Optional FWD_SCOREBOARD_PERF_EN adds saturating forward/stall event counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 2,
  localparam int SEL_W     = clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic [REG_ADDR_W-1:0]         iss_rd,
  input  logic                          iss_reg_write,
  input  logic                          iss_is_load,
  input  logic                          flush,
  input  logic                          pipe_hold,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          load_stall
`ifdef FWD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                   fwd_count,
  output logic [31:0]                   stall_count
`endif
);
  fwd_ent_t           ent_q [FWD_DEPTH];
  fwd_ent_t           ent_d [FWD_DEPTH];
  logic [NUM_SRC-1:0] stall_v;
  assign load_stall = |stall_v;
  always_comb begin
    ent_d = ent_q;
    if (!pipe_hold) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) ent_d[k] = ent_q[k-1];
      ent_d[0] = (flush || load_stall) ? fwd_ent_t'('0)
               : fwd_ent_t'{valid: iss_reg_write && iss_rd != '0, rd: ENT_RD_W'(iss_rd), is_load: iss_is_load};
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) for (int k = 0; k < FWD_DEPTH; k++) ent_q[k] <= '0;
    else ent_q <= ent_d;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_ADDR_W(REG_ADDR_W),
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
    ) u_match (
      .addr_i (src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .used_i (src_used[i]),
      .ents_i (ent_q),
      .sel_o  (fwd_sel[i*SEL_W +: SEL_W]),
      .stall_o(stall_v[i])
    );
  end
`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] fwd_cnt_q, stall_cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (!pipe_hold) begin
      if (|fwd_sel && ~&fwd_cnt_q) fwd_cnt_q <= fwd_cnt_q + 32'd1;
      if (load_stall && ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  assign fwd_count   = fwd_cnt_q;
  assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scenarios plus random traffic against an instruction-history reference model.
module tb_fwd_scoreboard;
  localparam int NS = 2, AW = 5, D = 2, SW = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic             rst_n;
  logic [NS*AW-1:0] src_addr;
  logic [NS-1:0]    src_used;
  logic [AW-1:0]    iss_rd;
  logic             iss_reg_write, iss_is_load, flush, pipe_hold;
  logic [NS*SW-1:0] fwd_sel;
  logic             load_stall;
`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] fwd_count, stall_count;
  logic [31:0] m_fc = '0, m_sc = '0;
`endif
  fwd_scoreboard #(.NUM_SRC(NS), .REG_ADDR_W(AW), .FWD_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_used(src_used),
    .iss_rd(iss_rd), .iss_reg_write(iss_reg_write), .iss_is_load(iss_is_load),
    .flush(flush), .pipe_hold(pipe_hold), .fwd_sel(fwd_sel), .load_stall(load_stall)
`ifdef FWD_SCOREBOARD_PERF_EN
    , .fwd_count(fwd_count), .stall_count(stall_count)
`endif
  );
  typedef struct {bit wr; int rd; bit ld;} ins_t;
  ins_t hist[$];
  int n_cmp = 0, n_bad = 0;
  logic [NS*SW-1:0] obs_sel;
  logic             obs_stall;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Youngest instruction first; a source reads the newest earlier writer of its register.
  function automatic void model(output logic [NS*SW-1:0] sel, output logic st);
    sel = '0;
    st  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int  a;
      bit  found;
      a = int'(src_addr[i*AW +: AW]);
      found = 0;
      if (src_used[i] && a != 0)
        for (int j = 0; j < hist.size(); j++)
          if (!found && hist[j].wr && hist[j].rd == a) begin
            found = 1;
            if (j == 0 && hist[j].ld) st = 1'b1;
            else sel[i*SW +: SW] = SW'(j + 1);
          end
    end
  endfunction
  task automatic step(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] u,
                      input logic [AW-1:0] rd, input logic w, input logic ld,
                      input logic fl, input logic hd);
    logic [NS*SW-1:0] es;
    logic             est;
    src_addr = {a1, a0}; src_used = u; iss_rd = rd; iss_reg_write = w;
    iss_is_load = ld; flush = fl; pipe_hold = hd;
    @(negedge clk);
    model(es, est);
    obs_sel = fwd_sel;
    obs_stall = load_stall;
    chk("fwd_sel", 32'(fwd_sel), 32'(es));
    chk("load_stall", 32'(load_stall), 32'(est));
`ifdef FWD_SCOREBOARD_PERF_EN
    chk("fwd_count", fwd_count, m_fc);
    chk("stall_count", stall_count, m_sc);
`endif
    @(posedge clk);
    if (!rst_n) begin
      hist.delete();
`ifdef FWD_SCOREBOARD_PERF_EN
      m_fc = '0; m_sc = '0;
`endif
    end else if (!hd) begin
      hist.push_front((fl || est) ? ins_t'{0, 0, 0} : ins_t'{w, int'(rd), ld});
      if (hist.size() > D) void'(hist.pop_back());
`ifdef FWD_SCOREBOARD_PERF_EN
      if (es != '0 && m_fc != 32'hFFFF_FFFF) m_fc++;
      if (est && m_sc != 32'hFFFF_FFFF) m_sc++;
`endif
    end
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(3, 3, 3, 3, 1, 1, 0, 1);
    rst_n = 1'b1;
    step(3, 3, 3, 0, 0, 0, 0, 0);
    chk("rst_sel", 32'(obs_sel), 0);
    chk("rst_stall", 32'(obs_stall), 0);
    step(0, 0, 0, 3, 1, 0, 0, 0);
    step(3, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("add_fwd", 32'(obs_sel[1:0]), 1);
    chk("add_nostall", 32'(obs_stall), 0);
    step(0, 0, 0, 3, 1, 0, 0, 0);
    step(0, 0, 0, 3, 1, 0, 0, 0);
    step(0, 3, 2'b10, 0, 0, 0, 0, 0);
    chk("youngest", 32'(obs_sel[3:2]), 1);
    step(0, 0, 0, 5, 1, 1, 0, 0);
    step(5, 0, 2'b01, 6, 1, 0, 0, 0);
    chk("lw_stall", 32'(obs_stall), 1);
    chk("lw_sel0", 32'(obs_sel[1:0]), 0);
    step(5, 0, 2'b01, 6, 1, 0, 0, 0);
    chk("lw_fwd2", 32'(obs_sel[1:0]), 2);
    chk("lw_unstall", 32'(obs_stall), 0);
    step(0, 0, 0, 5, 1, 1, 0, 0);
    step(5, 5, 2'b11, 0, 0, 0, 0, 0);
    chk("dual_stall", 32'(obs_stall), 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 2'b11, 0, 0, 0, 0, 0);
    chk("r0_sel", 32'(obs_sel), 0);
    step(0, 0, 0, 9, 1, 0, 0, 0);
    step(9, 9, 2'b00, 0, 0, 0, 0, 0);
    chk("unused_sel", 32'(obs_sel), 0);
    step(0, 0, 0, 7, 1, 0, 0, 0);
    repeat (3) begin
      step(7, 0, 2'b01, 0, 0, 0, 1, 1);
      chk("hold_sel", 32'(obs_sel[1:0]), 1);
    end
    step(7, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("post_hold", 32'(obs_sel[1:0]), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 7, 1, 0, 1, 0);
    step(7, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("flush_sel", 32'(obs_sel[1:0]), 0);
    step(0, 0, 0, 5, 1, 1, 0, 0);
    rst_n = 1'b0;
    step(5, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", 32'(obs_stall), 1);
    rst_n = 1'b1;
    step(5, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("rst_mid_stall", 32'(obs_stall), 0);
    chk("rst_mid_sel", 32'(obs_sel), 0);
    repeat (3000) begin
      rst_n = ($urandom_range(0, 63) != 0);
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
